// File: rtl/ras_stack_pkg.sv
// rtl/ras_stack_pkg.sv - shared fetch RAS encodings and defaults
package ras_stack_pkg;

  localparam int RAS_DEPTH_DEFAULT = 16;

  // Same encoding the F1 branch decoder drives on its RAS control lines
  typedef enum logic [1:0] {
    RAS_NONE    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_POPPUSH = 2'b11
  } ras_ctrl_e;

  function automatic logic [63:0] ras_ret_addr(input logic [63:0] call_pc);
    return call_pc + 64'd4;
  endfunction

endpackage

// File: rtl/ras_stack_if.sv
// rtl/ras_stack_if.sv - decoder/backend to return address stack bundle
interface ras_stack_if #(
  parameter int PTR_W = 4,
  parameter int CNT_W = 5
);
  logic             ras_vld_i;
  logic [1:0]       ras_ctrl_i;
  logic [63:0]      ras_data_i;
  logic             fetch_stall_i;
  logic             recover_vld_i;
  logic [PTR_W-1:0] recover_ptr_i;
  logic [CNT_W-1:0] recover_cnt_i;
  logic [63:0]      recover_top_i;
  logic [63:0]      ras_top_o;
  logic             ras_empty_o;
  logic [PTR_W-1:0] chkpt_ptr_o;
  logic [CNT_W-1:0] chkpt_cnt_o;
  logic [63:0]      chkpt_top_o;

  modport master (
    output ras_vld_i, ras_ctrl_i, ras_data_i, fetch_stall_i,
    output recover_vld_i, recover_ptr_i, recover_cnt_i, recover_top_i,
    input  ras_top_o, ras_empty_o, chkpt_ptr_o, chkpt_cnt_o, chkpt_top_o
  );

  modport slave (
    input  ras_vld_i, ras_ctrl_i, ras_data_i, fetch_stall_i,
    input  recover_vld_i, recover_ptr_i, recover_cnt_i, recover_top_i,
    output ras_top_o, ras_empty_o, chkpt_ptr_o, chkpt_cnt_o, chkpt_top_o
  );
endinterface

// File: rtl/ras_stack_mem.sv
// rtl/ras_stack_mem.sv - DEPTHx64 register array, one sync write, one async read
module ras_stack_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 64'd0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - F1 return address stack with checkpoint/repair
module ras_stack
  import ras_stack_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input logic        clk_i,
  input logic        rst_i,
  ras_stack_if.slave ras
);

  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             upd;
  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [63:0]      mem_wdata;
  logic [63:0]      top;
  logic [63:0]      ret;

  // Recover wins over stall and over the decoder's same-cycle request
  assign upd = ras.ras_vld_i & ~ras.fetch_stall_i & ~ras.recover_vld_i;
  assign ret = ras_ret_addr(ras.ras_data_i);

  always_comb begin
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = ret;
    if (ras.recover_vld_i) begin
      ptr_nxt   = ras.recover_ptr_i;
      cnt_nxt   = ras.recover_cnt_i;
      mem_we    = 1'b1;
      mem_waddr = ras.recover_ptr_i;
      mem_wdata = ras.recover_top_i;
    end else if (upd) begin
      case (ras_ctrl_e'(ras.ras_ctrl_i))
        RAS_PUSH: begin
          ptr_nxt   = ptr + PTR_W'(1);
          mem_we    = 1'b1;
          mem_waddr = ptr + PTR_W'(1);
          // Full stack overwrites the oldest entry; count saturates
          if (cnt != CNT_W'(DEPTH)) cnt_nxt = cnt + CNT_W'(1);
        end
        RAS_POP: begin
          if (cnt != '0) begin
            ptr_nxt = ptr - PTR_W'(1);
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        RAS_POPPUSH: begin
          mem_we = 1'b1;
          if (cnt == '0) cnt_nxt = CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      cnt <= '0;
    end else begin
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end

  ras_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (ptr),
    .rdata (top)
  );

  assign ras.ras_top_o   = top;
  assign ras.ras_empty_o = (cnt == '0);
  assign ras.chkpt_ptr_o = ptr;
  assign ras.chkpt_cnt_o = cnt;
  assign ras.chkpt_top_o = top;

endmodule
